receptor_serial: RTL

Serial front end for the character decoder. Receives asynchronous bit-serial frames on one line, checks start, odd parity and stop bits, and presents each good 7-bit character with a one-cycle `Controle` strobe. Its `Caractere`/`Controle` outputs drive the decoder's `Entrada`/`Controle` inputs directly. Bad frames are dropped and flagged on `Erro`.

---
 rtl/receptor_serial.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/receptor_serial.sv
// receptor_serial: asynchronous serial receiver for the character decoder.
// Frame: start(0), 7 data bits MSB first, odd parity, stop(1).
// Good characters are presented on Caractere with a one-cycle Controle strobe;
// parity or stop errors produce a single one-cycle Erro pulse.
module receptor_serial #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Serial_in,
    output logic [6:0] Caractere,
    output logic       Controle,
    output logic       Erro,
    output logic       Codigo_conhecido,
    output logic       Ocupado
);

    localparam int CNT_W = $clog2(CICLOS_POR_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CICLOS_POR_BIT - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        START,
        DADOS,
        PARIDADE,
        STOP,
        ESPERA_LINHA
    } estado_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [6:0] dado, input logic par);
        return ^{dado, par};
    endfunction

    // Membership in the decoder's table of known codes C1..C8.
    function automatic logic codigo_valido(input logic [6:0] dado);
        case (dado)
            7'b1100000, 7'b1000100, 7'b1111100, 7'b1011010,
            7'b1101110, 7'b1001001, 7'b1110101, 7'b1010011: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    logic             sync_p0;
    logic             sync_p1;
    logic             s;

    estado_t          estado;
    estado_t          estado_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       nbits;
    logic [2:0]       nbits_n;

    logic [6:0]       dado_sr;
    logic             par_bit;

    logic             shift_en;
    logic             par_en;
    logic             carga_ok;
    logic             carga_erro;

    assign s       = sync_p1;
    assign Ocupado = (estado != OCIOSO);

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= Serial_in;
            sync_p1 <= sync_p0;
        end
    end

    // FSM state and bit-timing counters.
    always_ff @(posedge clk) begin
        if (Reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
            nbits  <= '0;
        end else begin
            estado <= estado_n;
            cnt    <= cnt_n;
            nbits  <= nbits_n;
        end
    end

    // Next-state logic: mid-bit sampling relative to the synchronized start edge.
    always_comb begin
        estado_n   = estado;
        cnt_n      = cnt + CNT_W'(1);
        nbits_n    = nbits;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        carga_ok   = 1'b0;
        carga_erro = 1'b0;
        case (estado)
            OCIOSO: begin
                cnt_n   = '0;
                nbits_n = '0;
                if (!s) estado_n = START;
            end
            START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_n    = '0;
                    estado_n = s ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_n    = '0;
                    shift_en = 1'b1;
                    nbits_n  = nbits + 3'd1;
                    if (nbits == 3'd6) estado_n = PARIDADE;
                end
            end
            PARIDADE: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_n    = '0;
                    par_en   = 1'b1;
                    estado_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_n = '0;
                    if (s) begin
                        // A bad parity with a good stop is still a single error.
                        if (parity_ok(dado_sr, par_bit)) carga_ok = 1'b1;
                        else                             carga_erro = 1'b1;
                        estado_n = OCIOSO;
                    end else begin
                        carga_erro = 1'b1;
                        estado_n   = ESPERA_LINHA;
                    end
                end
            end
            ESPERA_LINHA: begin
                // A held-low line (break) must return high before a new start is seen.
                cnt_n = '0;
                if (s) estado_n = OCIOSO;
            end
            default: begin
                cnt_n    = '0;
                nbits_n  = '0;
                estado_n = OCIOSO;
            end
        endcase
    end

    // Internal data shift register and captured parity bit.
    always_ff @(posedge clk) begin
        if (shift_en) dado_sr <= {dado_sr[5:0], s};
        if (par_en)   par_bit <= s;
    end

    // Output register: character, known-code flag and the one-cycle strobes.
    always_ff @(posedge clk) begin
        if (Reset) begin
            Caractere        <= '0;
            Codigo_conhecido <= 1'b0;
            Controle         <= 1'b0;
            Erro             <= 1'b0;
        end else begin
            Controle <= carga_ok;
            Erro     <= carga_erro;
            if (carga_ok) begin
                Caractere        <= dado_sr;
                Codigo_conhecido <= codigo_valido(dado_sr);
            end
        end
    end

endmodule
